// File: rtl/rand_gen_pkg.sv
// Shared types and constants for the rand_gen draw engine: FSM encoding,
// default LFSR tap masks and the zero-seed substitution helper.
package rand_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      STEP = ST_STEP,
      DONE = ST_DONE
   } state_e;

   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;

   // An all-zero LFSR state is a lock-up state, so a zero seed becomes 1.
   function automatic logic [63:0] seed_or_one(input logic [63:0] seed);
      return (seed == 64'd0) ? 64'd1 : seed;
   endfunction

endpackage

// File: rtl/rand_lfsr_core.sv
// Fibonacci LFSR state register with seed-load and shift enables; the
// next (shifted) state is exposed combinationally for candidate evaluation.
module rand_lfsr_core
   import rand_gen_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
   parameter int unsigned      SEED  = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             shift_i,
   output logic [WIDTH-1:0] next_state_o
);

   localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(seed_or_one(64'(WIDTH'(SEED))));

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] next_state;

   assign next_state   = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
   assign next_state_o = next_state;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = WIDTH'(seed_or_one(64'(seed_i)));
      end else if (shift_i) begin
         state_d = next_state;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/rand_gen.sv
// Pseudo-random draw engine: STEPS LFSR shifts per draw, valid/ready output.
// Define RAND_GEN_RANGE_EN to enable rejection sampling against limit_i.
module rand_gen
   import rand_gen_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter int unsigned      OUT_W = 5,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
   parameter int unsigned      SEED  = 1,
   parameter int unsigned      STEPS = OUT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             seed_valid_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             next_i,
   output logic             ready_o,
   output logic             rand_valid_o,
   input  logic             rand_ready_i,
   output logic [OUT_W-1:0] rand_o,
   input  logic [OUT_W:0]   limit_i
);

   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEPS - 1);

   state_e           fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] rand_q, rand_d;
   logic             load, shift;
   logic [WIDTH-1:0] next_state;
   logic [OUT_W-1:0] cand;
   logic             cand_ok;
   logic             next_state_unused;

   rand_lfsr_core #(
      .WIDTH(WIDTH),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (load),
      .seed_i      (seed_i),
      .shift_i     (shift),
      .next_state_o(next_state)
   );

   // Only the low OUT_W bits form the candidate; the rest feed the LFSR alone.
   assign cand              = next_state[OUT_W-1:0];
   assign next_state_unused = ^next_state;

`ifdef RAND_GEN_RANGE_EN
   assign cand_ok = (limit_i == '0) || ({1'b0, cand} < limit_i);
`else
   logic limit_unused;
   assign limit_unused = ^limit_i;
   assign cand_ok      = 1'b1;
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      rand_d = rand_q;
      load   = 1'b0;
      shift  = 1'b0;
      if (seed_valid_i) begin
         load  = 1'b1;
         fsm_d = IDLE;
         cnt_d = '0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               if (next_i) begin
                  fsm_d = STEP;
                  cnt_d = CNT_RELOAD;
               end
            end
            STEP: begin
               shift = 1'b1;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (cand_ok) begin
                  rand_d = cand;
                  fsm_d  = DONE;
               end else begin
                  cnt_d = CNT_RELOAD;
               end
            end
            DONE: begin
               if (rand_ready_i) begin
                  fsm_d = IDLE;
               end
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_ni) begin
         fsm_q  <= IDLE;
         cnt_q  <= '0;
         rand_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         rand_q <= rand_d;
      end
   end

   assign ready_o      = (fsm_q == IDLE);
   assign rand_valid_o = (fsm_q == DONE);
   assign rand_o       = rand_q;

endmodule

// File: doc/rand_gen.md
# rand_gen

Parametrised pseudo-random draw engine for the game datapath. It is the next generation of the 5-bit free-running LFSR and replaces it. The block holds a WIDTH-bit Fibonacci LFSR and advances it STEPS shifts per draw to decorrelate successive outputs. Each draw is delivered through a valid/ready handshake, with optional rejection sampling into a runtime range.

## Interface
- WIDTH, 16: LFSR state width, ≥ 4
- OUT_W, 5: output width, ≤ WIDTH
- TAPS, 16'hB400: feedback mask; feedback bit = XOR of state bits selected by mask
- SEED, 1: reset seed; 0 is replaced by 1
- STEPS, OUT_W: shifts per draw, ≥ 1
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- seed_valid_i  in  1  load seed_i this cycle
- seed_i  in  WIDTH  seed value
- next_i  in  1  draw request
- ready_o  out  1  request accepted when next_i & ready_o
- rand_valid_o  out  1  draw result valid
- rand_ready_i  in  1  consumer accepts result
- rand_o  out  OUT_W  draw result
- limit_i  in  OUT_W+1  exclusive upper bound for results; 0 = unbounded (range build only)

## Operation
- Shift: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
- State never holds 0. A seed of 0, from the parameter or from seed_i, loads 1.
- FSM states: IDLE, STEP, DONE. Encoding comes from the package.
- IDLE: ready_o=1. On next_i, go to STEP with step counter = STEPS-1.
- STEP: one shift per cycle. Decrement the counter while it is nonzero.
  - At counter 0 the final shift takes place and the candidate next_state[OUT_W-1:0] is evaluated.
  - If the candidate is accepted, register it into rand_o and go to DONE.
  - If it is rejected, reload the counter to STEPS-1 and stay in STEP.
- DONE: rand_valid_o=1, and rand_o is held stable. On rand_ready_i, go to IDLE. next_i is ignored outside IDLE.
- seed_valid_i has priority over everything, in any state:
  - load the seed (0→1), go to IDLE, and drop rand_valid_o;
  - a draw in flight is discarded;
  - rand_o keeps its last value.
- State does not advance in IDLE or DONE.

## Timing
- Reset values: state=SEED (0→1), FSM=IDLE, ready_o=1, rand_valid_o=0, rand_o=0, counter=0.
- Request accepted at edge E0. Shifts occur at E1..E_STEPS. rand_valid_o is high after E_STEPS, so the minimum latency is STEPS+1 cycles.
- Each rejection adds STEPS cycles.
- Throughput: one draw per STEPS+2 cycles with rand_ready_i tied high. ready_o is high in the cycle after the DONE handshake.
- seed_valid_i at edge E: state = seed after E and ready_o=1 in the following cycle. If next_i is also high in IDLE, the seed wins and the request is dropped.
- Asynchronous reset mid-draw returns all registers to reset values immediately.

## Configuration
- RAND_GEN_RANGE_EN defined:
  - candidate accepted iff limit_i==0 or candidate < limit_i;
  - limit_i is sampled at each candidate evaluation;
  - limit_i ≥ 2^OUT_W behaves as unbounded.
- Undefined: limit_i is ignored, every candidate is accepted, and the STEP state never reloads.

## Structure
- Package rand_gen_pkg contains:
  - state_e enum (IDLE, STEP, DONE);
  - default tap constants for WIDTH 8 (8'hB8) and 16 (16'hB400);
  - a function computing the zero-substituted seed.
- Sub-module rand_lfsr_core holds the state register with load/shift enables and exposes next_state combinationally. rand_gen contains the FSM, the counter, the range check and the output register.

## Test plan
Defaults WIDTH=16, OUT_W=5, STEPS=5, SEED=1, TAPS=16'hB400, rand_ready_i=1 unless stated.
- Reset, then three draws. Required: rand_o = 0, 0, 22; state afterwards 16'h8016; rand_valid_o rises 6 cycles after each accept.
- RAND_GEN_RANGE_EN, limit_i=16, third draw as above. Candidate 22 and then 16 are both rejected. Required: rand_o=8 after 15 shifts, valid 16 cycles after accept, state 16'h5A08.
- seed_valid_i with seed_i=0, then one draw. Required: state loads 16'h0001 and rand_o=0.
- rand_ready_i low for 10 cycles in DONE, with next_i pulsed. Required: rand_valid_o and rand_o stable, ready_o=0, no shifts, request ignored.
- seed_valid_i at the third STEP cycle of a draw. Required: no rand_valid_o, state = seed_i, ready_o=1 the next cycle.
- rst_ni asserted asynchronously mid-STEP. Required: outputs return to reset values without waiting for a clock edge.
